axi4_lite_arbiter_2to1: RTL and testbench
=========================================

AXI4_LITE_ARBITER_2TO1 -- requirements
Module: axi4_lite_arbiter_2to1

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all AW/AR paths.
REQ-002 Parameter DATA_W, default 32, data width of all W/R paths; WSTRB width SHALL be DATA_W/8.
REQ-003 iCLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 iRST  in  1  asynchronous active-low reset.
REQ-005 sN_AWVALID/sN_AWPROT/sN_AWADDR  in  1/3/ADDR_W  write address from master N (N=0,1); sN_AWREADY out 1.
REQ-006 sN_WVALID/sN_WSTRB/sN_WDATA  in  1/DATA_W/8/DATA_W  write data from master N; sN_WREADY out 1.
REQ-007 sN_BVALID/sN_BRESP  out  1/2  write response to master N; sN_BREADY in 1.
REQ-008 sN_ARVALID/sN_ARPROT/sN_ARADDR  in  1/3/ADDR_W  read address from master N; sN_ARREADY out 1.
REQ-009 sN_RVALID/sN_RDATA/sN_RRESP  out  1/DATA_W/2  read data to master N; sN_RREADY in 1.
REQ-010 m_AW*/m_W*/m_AR*  out, same widths  forwarded request channels to the single shared slave; m_AWREADY/m_WREADY/m_ARREADY in 1.
REQ-011 m_BVALID/m_BRESP and m_RVALID/m_RDATA/m_RRESP  in  slave responses; m_BREADY/m_RREADY out 1.
REQ-012 oGRANT  out  2  one-hot owning master (bit N = master N), 2'b00 when idle.
REQ-013 oBUSY  out  1  high whenever FSM is not IDLE.

Function
REQ-014 Exactly one transaction (one write or one read) SHALL be outstanding on the m_ side at any time.
REQ-015 FSM states SHALL be IDLE, WADDR, WRESP, RADDR, RDATA.
REQ-016 Request of master N SHALL be wreqN = sN_AWVALID & sN_WVALID, rreqN = sN_ARVALID, reqN = wreqN | rreqN.
REQ-017 In IDLE, if exactly one master requests, it SHALL win; if both request, the master not equal to last_grant SHALL win (round-robin).
REQ-018 On a win the FSM SHALL register sel and last_grant = winner and move to WADDR if wreq of winner is high, else RADDR (write beats read within one master); arbitration latency is one cycle.
REQ-019 In IDLE all m_*VALID, m_BREADY, m_RREADY and all sN_* READY/VALID outputs SHALL be 0; m_ address/data/strobe/prot SHALL be 0.
REQ-020 WADDR: m_AW*/m_W* SHALL equal sel master inputs combinationally; m_AWREADY/m_WREADY SHALL route only to sel master.
REQ-021 WADDR SHALL track aw_done/w_done flags, set on respective VALID&READY; once a channel handshakes its m_ VALID SHALL drop to 0; FSM SHALL enter WRESP in the cycle after both are done (same-cycle handshakes allowed).
REQ-022 WRESP: sel sN_BVALID/sN_BRESP = m_BVALID/m_BRESP, m_BREADY = sel sN_BREADY; on m_BVALID & m_BREADY the FSM SHALL return to IDLE next cycle.
REQ-023 RADDR: m_AR* = sel inputs, m_ARREADY routed to sel; on m_ARVALID & m_ARREADY go to RDATA.
REQ-024 RDATA: sel sN_RVALID/RDATA/RRESP = m_R*, m_RREADY = sel sN_RREADY; on handshake return to IDLE.
REQ-025 The non-selected master SHALL see all its READY and VALID outputs at 0, RDATA 0, BRESP/RRESP 2'b00, at all times.
REQ-026 Responses (BRESP/RRESP) SHALL pass unmodified; the block SHALL generate no responses itself.
REQ-027 A master dropping VALID before handshake is a protocol violation; behaviour is unspecified but the FSM SHALL not leave its state until the handshake.
REQ-028 oGRANT SHALL be one-hot of sel in non-IDLE states, 2'b00 in IDLE.

Reset
REQ-029 On iRST low, FSM SHALL go to IDLE, aw_done = w_done = 0, sel = 0, last_grant = 1 (master 0 wins the first tie); all outputs SHALL take REQ-019 values immediately.
REQ-030 Reset mid-transaction SHALL abandon it without completing any handshake.

Verification
REQ-031 Master 0 write 0x10/0xDEADBEEF, slave AWREADY=WREADY=1, BVALID after 2 cycles -> m_AWADDR=0x10, s0_BVALID=1 BRESP=00, s1 outputs 0, oBUSY low after B handshake.
REQ-032 Both masters read simultaneously from IDLE after reset, addresses 0x4/0x8 -> master 0 served first (0x4), then master 1 (0x8); repeat tie -> master 0 served first again after master 1 was last.
REQ-033 Master 1 asserts both write and read at once -> write completes first, read granted in a later arbitration.
REQ-034 Slave asserts WREADY 3 cycles before AWREADY -> m_WVALID drops after W handshake, WRESP entered only after AW handshake.
REQ-035 Slave returns RRESP=2'b10 with RDATA=0xCAFE0001, master holds RREADY low 2 cycles -> s0_RVALID held, data/resp unchanged until RREADY.
REQ-036 iRST pulled low in WRESP -> oGRANT=00, s0_BVALID=0, next request arbitrated cleanly.

Source files
------------

// File: rtl/axi4_lite_arbiter_2to1_if.sv
// AXI4-Lite channel bundle shared by the two upstream masters and the single downstream slave.
// The master modport issues requests; the slave modport receives them and returns responses.
interface axi4_lite_arbiter_2to1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [2:0]        awprot;
  logic [ADDR_W-1:0] awaddr;

  logic                wvalid;
  logic                wready;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   wdata;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  logic              arvalid;
  logic              arready;
  logic [2:0]        arprot;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awprot, awaddr, wvalid, wstrb, wdata, bready,
           arvalid, arprot, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awprot, awaddr, wvalid, wstrb, wdata, bready,
           arvalid, arprot, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter with a single outstanding transaction,
// round-robin on ties and write-before-read within one master.
module axi4_lite_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                            iCLK,
  input  logic                            iRST,
  axi4_lite_arbiter_2to1_if.slave         s0,
  axi4_lite_arbiter_2to1_if.slave         s1,
  axi4_lite_arbiter_2to1_if.master        m,
  output logic [1:0]                      oGRANT,
  output logic                            oBUSY
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  logic [2:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       winner;

  logic                in_waddr, in_wresp, in_raddr, in_rdata;
  logic                wreq0, wreq1, req0, req1;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [2:0]          sel_awprot, sel_arprot;
  logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;

  logic                v_awready, v_wready, v_bvalid, v_arready, v_rvalid;
  logic [1:0]          v_bresp, v_rresp;
  logic [DATA_W-1:0]   v_rdata;

  assign in_waddr = (state_q == S_WADDR);
  assign in_wresp = (state_q == S_WRESP);
  assign in_raddr = (state_q == S_RADDR);
  assign in_rdata = (state_q == S_RDATA);

  assign wreq0 = s0.awvalid & s0.wvalid;
  assign wreq1 = s1.awvalid & s1.wvalid;
  assign req0  = wreq0 | s0.arvalid;
  assign req1  = wreq1 | s1.arvalid;

  // Request view of whichever master currently owns the slave.
  assign sel_awvalid = sel_q ? s1.awvalid : s0.awvalid;
  assign sel_awprot  = sel_q ? s1.awprot  : s0.awprot;
  assign sel_awaddr  = sel_q ? s1.awaddr  : s0.awaddr;
  assign sel_wvalid  = sel_q ? s1.wvalid  : s0.wvalid;
  assign sel_wstrb   = sel_q ? s1.wstrb   : s0.wstrb;
  assign sel_wdata   = sel_q ? s1.wdata   : s0.wdata;
  assign sel_bready  = sel_q ? s1.bready  : s0.bready;
  assign sel_arvalid = sel_q ? s1.arvalid : s0.arvalid;
  assign sel_arprot  = sel_q ? s1.arprot  : s0.arprot;
  assign sel_araddr  = sel_q ? s1.araddr  : s0.araddr;
  assign sel_rready  = sel_q ? s1.rready  : s0.rready;

  // A channel that already handshook is masked so the slave never sees a second beat.
  assign m.awvalid = in_waddr & sel_awvalid & ~aw_done_q;
  assign m.awprot  = in_waddr ? sel_awprot : '0;
  assign m.awaddr  = in_waddr ? sel_awaddr : '0;
  assign m.wvalid  = in_waddr & sel_wvalid & ~w_done_q;
  assign m.wstrb   = in_waddr ? sel_wstrb : '0;
  assign m.wdata   = in_waddr ? sel_wdata : '0;
  assign m.bready  = in_wresp & sel_bready;
  assign m.arvalid = in_raddr & sel_arvalid;
  assign m.arprot  = in_raddr ? sel_arprot : '0;
  assign m.araddr  = in_raddr ? sel_araddr : '0;
  assign m.rready  = in_rdata & sel_rready;

  assign v_awready = in_waddr & ~aw_done_q & m.awready;
  assign v_wready  = in_waddr & ~w_done_q & m.wready;
  assign v_bvalid  = in_wresp & m.bvalid;
  assign v_bresp   = in_wresp ? m.bresp : 2'b00;
  assign v_arready = in_raddr & m.arready;
  assign v_rvalid  = in_rdata & m.rvalid;
  assign v_rdata   = in_rdata ? m.rdata : '0;
  assign v_rresp   = in_rdata ? m.rresp : 2'b00;

  assign aw_hs = in_waddr & sel_awvalid & ~aw_done_q & m.awready;
  assign w_hs  = in_waddr & sel_wvalid & ~w_done_q & m.wready;
  assign b_hs  = v_bvalid & sel_bready;
  assign ar_hs = in_raddr & sel_arvalid & m.arready;
  assign r_hs  = v_rvalid & sel_rready;

  assign s0.awready = ~sel_q & v_awready;
  assign s1.awready =  sel_q & v_awready;
  assign s0.wready  = ~sel_q & v_wready;
  assign s1.wready  =  sel_q & v_wready;
  assign s0.bvalid  = ~sel_q & v_bvalid;
  assign s1.bvalid  =  sel_q & v_bvalid;
  assign s0.bresp   = sel_q ? 2'b00 : v_bresp;
  assign s1.bresp   = sel_q ? v_bresp : 2'b00;
  assign s0.arready = ~sel_q & v_arready;
  assign s1.arready =  sel_q & v_arready;
  assign s0.rvalid  = ~sel_q & v_rvalid;
  assign s1.rvalid  =  sel_q & v_rvalid;
  assign s0.rdata   = sel_q ? '0 : v_rdata;
  assign s1.rdata   = sel_q ? v_rdata : '0;
  assign s0.rresp   = sel_q ? 2'b00 : v_rresp;
  assign s1.rresp   = sel_q ? v_rresp : 2'b00;

  assign oBUSY  = (state_q != S_IDLE);
  assign oGRANT = oBUSY ? {sel_q, ~sel_q} : 2'b00;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    winner    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // On a tie the master that did not win last time goes next.
          winner  = (req0 & req1) ? ~last_q : req1;
          sel_d   = winner;
          last_d  = winner;
          state_d = (winner ? wreq1 : wreq0) ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) begin
          state_d   = S_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WRESP: if (b_hs)  state_d = S_IDLE;
      S_RADDR: if (ar_hs) state_d = S_RDATA;
      S_RDATA: if (r_hs)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter: writes, reads, ties, split handshakes,
// response back-pressure and reset mid-transaction, with hand-computed expectations.
module tb_axi4_lite_arbiter_2to1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       busy;
  int         checks = 0;
  int         failures = 0;

  axi4_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi4_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi4_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi4_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .iCLK   (clk),
    .iRST   (rst_n),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .oGRANT (grant),
    .oBUSY  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awvalid = 0; s0_if.awprot = 0; s0_if.awaddr = 0; s0_if.wvalid = 0;
    s0_if.wstrb = 0; s0_if.wdata = 0; s0_if.bready = 0; s0_if.arvalid = 0;
    s0_if.arprot = 0; s0_if.araddr = 0; s0_if.rready = 0;
    s1_if.awvalid = 0; s1_if.awprot = 0; s1_if.awaddr = 0; s1_if.wvalid = 0;
    s1_if.wstrb = 0; s1_if.wdata = 0; s1_if.bready = 0; s1_if.arvalid = 0;
    s1_if.arprot = 0; s1_if.araddr = 0; s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
  endtask

  // Caller leaves the arbiter in IDLE with master n's read request already raised.
  task automatic serve_read(input bit n, input logic [31:0] addr, input logic [31:0] data);
    m_if.arready = 1;
    cyc();
    check($sformatf("rd%0d_grant", n), 64'(grant), n ? 64'h2 : 64'h1);
    check($sformatf("rd%0d_araddr", n), 64'(m_if.araddr), 64'(addr));
    check($sformatf("rd%0d_arready", n), 64'(n ? s1_if.arready : s0_if.arready), 64'h1);
    check($sformatf("rd%0d_other_arready", n), 64'(n ? s0_if.arready : s1_if.arready), 64'h0);
    cyc();
    if (n) s1_if.arvalid = 0; else s0_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rdata = data; m_if.rresp = 2'b00;
    settle();
    check($sformatf("rd%0d_rvalid", n), 64'(n ? s1_if.rvalid : s0_if.rvalid), 64'h1);
    check($sformatf("rd%0d_rdata", n), 64'(n ? s1_if.rdata : s0_if.rdata), 64'(data));
    check($sformatf("rd%0d_other_rdata", n), 64'(n ? s0_if.rdata : s1_if.rdata), 64'h0);
    cyc();
    m_if.rvalid = 0; m_if.rdata = 0;
    settle();
    check($sformatf("rd%0d_idle_busy", n), 64'(busy), 64'h0);
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state with a write already being requested by master 0.
    s0_if.awvalid = 1; s0_if.awaddr = 32'h10; s0_if.wvalid = 1;
    s0_if.wdata = 32'hDEAD_BEEF; s0_if.wstrb = 4'hF; s0_if.bready = 1;
    settle();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'h0);
    check("rst_m_awaddr", 64'(m_if.awaddr), 64'h0);
    check("rst_s0_awready", 64'(s0_if.awready), 64'h0);

    // Master 0 single write, slave ready immediately, BVALID two cycles after WRESP entry.
    rst_n = 1; m_if.awready = 1; m_if.wready = 1;
    settle();
    check("w0_idle_grant", 64'(grant), 64'h0);
    cyc();
    check("w0_grant", 64'(grant), 64'h1);
    check("w0_m_awaddr", 64'(m_if.awaddr), 64'h10);
    check("w0_m_wdata", 64'(m_if.wdata), 64'hDEAD_BEEF);
    check("w0_m_wstrb", 64'(m_if.wstrb), 64'hF);
    check("w0_s0_awready", 64'(s0_if.awready), 64'h1);
    check("w0_s1_awready", 64'(s1_if.awready), 64'h0);
    cyc();
    s0_if.awvalid = 0; s0_if.wvalid = 0;
    settle();
    check("w0_wresp_m_awvalid", 64'(m_if.awvalid), 64'h0);
    check("w0_wresp_m_bready", 64'(m_if.bready), 64'h1);
    check("w0_wresp_s0_bvalid_early", 64'(s0_if.bvalid), 64'h0);
    cyc();
    cyc();
    m_if.bvalid = 1; m_if.bresp = 2'b00;
    settle();
    check("w0_s0_bvalid", 64'(s0_if.bvalid), 64'h1);
    check("w0_s0_bresp", 64'(s0_if.bresp), 64'h0);
    check("w0_s1_bvalid", 64'(s1_if.bvalid), 64'h0);
    check("w0_busy_wresp", 64'(busy), 64'h1);
    cyc();
    m_if.bvalid = 0;
    settle();
    check("w0_busy_done", 64'(busy), 64'h0);
    check("w0_grant_done", 64'(grant), 64'h0);

    // Fresh reset, then simultaneous reads: master 0 first, then 1, and again on a repeat tie.
    clear_inputs();
    rst_n = 0;
    cyc();
    rst_n = 1;
    s0_if.rready = 1; s1_if.rready = 1;
    s0_if.arvalid = 1; s0_if.araddr = 32'h4;
    s1_if.arvalid = 1; s1_if.araddr = 32'h8;
    serve_read(1'b0, 32'h4, 32'h1111_0004);
    serve_read(1'b1, 32'h8, 32'h2222_0008);
    s0_if.arvalid = 1; s1_if.arvalid = 1;
    serve_read(1'b0, 32'h4, 32'h3333_0004);
    serve_read(1'b1, 32'h8, 32'h4444_0008);

    // Master 1 raises write and read together: write first, read in a later arbitration.
    clear_inputs();
    s1_if.rready = 1; s1_if.bready = 1;
    s1_if.awvalid = 1; s1_if.awaddr = 32'h20; s1_if.wvalid = 1;
    s1_if.wdata = 32'h1234_5678; s1_if.wstrb = 4'h3;
    s1_if.arvalid = 1; s1_if.araddr = 32'h30;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    cyc();
    check("wr1_grant", 64'(grant), 64'h2);
    check("wr1_m_awvalid", 64'(m_if.awvalid), 64'h1);
    check("wr1_m_arvalid", 64'(m_if.arvalid), 64'h0);
    check("wr1_m_awaddr", 64'(m_if.awaddr), 64'h20);
    cyc();
    s1_if.awvalid = 0; s1_if.wvalid = 0;
    m_if.bvalid = 1; m_if.bresp = 2'b11;
    settle();
    check("wr1_s1_bvalid", 64'(s1_if.bvalid), 64'h1);
    check("wr1_s1_bresp", 64'(s1_if.bresp), 64'h3);
    check("wr1_s0_bresp", 64'(s0_if.bresp), 64'h0);
    cyc();
    m_if.bvalid = 0; m_if.bresp = 0;
    settle();
    check("wr1_idle_grant", 64'(grant), 64'h0);
    check("wr1_idle_m_arvalid", 64'(m_if.arvalid), 64'h0);
    serve_read(1'b1, 32'h30, 32'h5555_0030);

    // WREADY three cycles ahead of AWREADY: W masked after its handshake, WRESP waits for AW.
    clear_inputs();
    s0_if.bready = 1;
    s0_if.awvalid = 1; s0_if.awaddr = 32'h40; s0_if.wvalid = 1; s0_if.wdata = 32'h55;
    s0_if.wstrb = 4'h1;
    m_if.wready = 1;
    cyc();
    check("split_m_wvalid_first", 64'(m_if.wvalid), 64'h1);
    check("split_m_awvalid_first", 64'(m_if.awvalid), 64'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("split_m_wvalid_masked%0d", i), 64'(m_if.wvalid), 64'h0);
      check($sformatf("split_s0_wready_masked%0d", i), 64'(s0_if.wready), 64'h0);
      check($sformatf("split_m_awvalid_held%0d", i), 64'(m_if.awvalid), 64'h1);
      check($sformatf("split_m_bready_not_yet%0d", i), 64'(m_if.bready), 64'h0);
    end
    m_if.awready = 1;
    settle();
    check("split_s0_awready", 64'(s0_if.awready), 64'h1);
    cyc();
    s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0;
    settle();
    check("split_wresp_m_bready", 64'(m_if.bready), 64'h1);
    check("split_wresp_m_awvalid", 64'(m_if.awvalid), 64'h0);
    m_if.bvalid = 1;
    cyc();
    m_if.bvalid = 0;
    settle();
    check("split_done_busy", 64'(busy), 64'h0);

    // Read response back-pressured by master 0 for two cycles.
    clear_inputs();
    s0_if.arvalid = 1; s0_if.araddr = 32'h50; m_if.arready = 1;
    cyc();
    check("bp_grant", 64'(grant), 64'h1);
    cyc();
    s0_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rdata = 32'hCAFE_0001; m_if.rresp = 2'b10;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("bp_s0_rvalid%0d", i), 64'(s0_if.rvalid), 64'h1);
      check($sformatf("bp_s0_rdata%0d", i), 64'(s0_if.rdata), 64'hCAFE_0001);
      check($sformatf("bp_s0_rresp%0d", i), 64'(s0_if.rresp), 64'h2);
      check($sformatf("bp_m_rready%0d", i), 64'(m_if.rready), 64'h0);
      cyc();
    end
    s0_if.rready = 1;
    settle();
    check("bp_m_rready_go", 64'(m_if.rready), 64'h1);
    check("bp_s1_rresp", 64'(s1_if.rresp), 64'h0);
    cyc();
    m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0; s0_if.rready = 0;
    settle();
    check("bp_done_busy", 64'(busy), 64'h0);

    // Reset asserted in WRESP while the slave is offering BVALID.
    clear_inputs();
    s0_if.bready = 1; s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.awaddr = 32'h70;
    m_if.awready = 1; m_if.wready = 1;
    cyc();
    cyc();
    s0_if.awvalid = 0; s0_if.wvalid = 0;
    settle();
    check("rstw_in_wresp", 64'(m_if.bready), 64'h1);
    m_if.bvalid = 1; rst_n = 0;
    settle();
    check("rstw_grant", 64'(grant), 64'h0);
    check("rstw_s0_bvalid", 64'(s0_if.bvalid), 64'h0);
    check("rstw_m_bready", 64'(m_if.bready), 64'h0);
    check("rstw_busy", 64'(busy), 64'h0);
    cyc();
    rst_n = 1; m_if.bvalid = 0;
    s1_if.rready = 1; s1_if.arvalid = 1; s1_if.araddr = 32'h60;
    serve_read(1'b1, 32'h60, 32'h6666_0060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
